// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared FSM encoding and opcode constants for the add/sub arbiter
package addsub_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic OP_ADD = 1'b1;
    localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/addsub_unit.sv
// rtl/addsub_unit.sv - combinational WIDTH-bit add/subtract with carry/borrow out
module addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] data,
    output logic             cout
);

    logic [WIDTH:0] sum;

    // Zero-extended subtract leaves the borrow in the top bit (1 iff a < b).
    always_comb begin
        if (op == OP_ADD) begin
            sum = {1'b0, a} + {1'b0, b};
        end else begin
            sum = {1'b0, a} - {1'b0, b};
        end
    end

    assign data = sum[WIDTH-1:0];
    assign cout = sum[WIDTH];

endmodule

// File: rtl/addsub_arbiter.sv
// rtl/addsub_arbiter.sv - round-robin arbiter sharing one add/sub unit among NREQ requesters
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_op,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_data,
    output logic                  rsp_cout,
    output logic                  busy
);

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_cout_q, rsp_cout_d;

    logic [NREQ-1:0]  grant;
    logic             found;
    logic [IDW-1:0]   win;
    logic             op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    int               idx;

    logic [WIDTH-1:0] u_data;
    logic             u_cout;

    // First pending requester at or after the rr pointer, wrapping around.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        win    = '0;
        op_sel = 1'b0;
        a_sel  = '0;
        b_sel  = '0;
        idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_q) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win        = idx[IDW-1:0];
                op_sel     = req_op[idx];
                a_sel      = req_a[idx*WIDTH +: WIDTH];
                b_sel      = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    addsub_unit #(.WIDTH(WIDTH)) u_addsub (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .data (u_data),
        .cout (u_cout)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_cout_d  = rsp_cout_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    op_d    = op_sel;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    id_d    = win;
                    rr_d    = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d  = u_data;
                rsp_cout_d  = u_cout;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            op_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    // Grant is masked during reset since the async clear already forces IDLE.
    assign req_ready = (rst_n && state_q == S_IDLE) ? grant : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// tb/tb_addsub_arbiter.sv - self-checking bench for addsub_arbiter
module tb_addsub_arbiter;

    localparam int WIDTH = 9;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int MODV  = 1 << WIDTH;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_op;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_data;
    logic                  rsp_cout;
    logic                  busy;

    always #5 clk = ~clk;

    addsub_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_cout  (rsp_cout),
        .busy      (busy)
    );

    typedef struct {
        int id;
        int data;
        int cout;
    } rsp_t;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   vcount = 0;
    int   last_g_cyc = 0;
    int   last_r_cyc = 0;
    int   gq[$];
    rsp_t rq[$];

    // Model: 0 = waiting for a grant, 1 = computing, 2 = presenting result.
    int m_phase = 0;
    int m_rr = 0;
    int m_id = 0, m_data = 0, m_cout = 0;
    int p_id = 0, p_data = 0, p_cout = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model_winner();
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_rr + k) % NREQ;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        int w;
        int a, b, s;
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_rsp_cout", rsp_cout, 0);
            m_phase = 0; m_rr = 0;
            m_id = 0; m_data = 0; m_cout = 0;
        end else begin
            w = (m_phase == 0) ? model_winner() : -1;
            chk("req_ready", req_ready, (w >= 0) ? (1 << w) : 0);
            chk("rsp_valid", rsp_valid, (m_phase == 2) ? 1 : 0);
            chk("busy", busy, (m_phase != 0) ? 1 : 0);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_cout", rsp_cout, m_cout);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    gq.push_back(i);
                    last_g_cyc = cyc;
                end
            end
            if (rsp_valid) vcount++;
            if (rsp_valid && rsp_ready) begin
                rq.push_back('{int'(rsp_id), int'(rsp_data), int'(rsp_cout)});
                last_r_cyc = cyc;
            end
            case (m_phase)
                0: if (w >= 0) begin
                    a = int'(req_a[w*WIDTH +: WIDTH]);
                    b = int'(req_b[w*WIDTH +: WIDTH]);
                    if (req_op[w]) begin
                        s = a + b;
                        p_data = s % MODV;
                        p_cout = (s >= MODV) ? 1 : 0;
                    end else begin
                        p_data = (a - b + MODV) % MODV;
                        p_cout = (a < b) ? 1 : 0;
                    end
                    p_id = w;
                    m_rr = (w + 1) % NREQ;
                    m_phase = 1;
                end
                1: begin
                    m_id = p_id; m_data = p_data; m_cout = p_cout;
                    m_phase = 2;
                end
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    task automatic set_req(input int i, input logic op, input int a, input int b);
        req_valid[i] = 1'b1;
        req_op[i] = op;
        req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
        req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
    endtask

    task automatic wait_grant(input int n);
        for (int i = 0; i < 200 && gq.size() < n; i++) @(posedge clk);
        #1;
        if (gq.size() < n) chk("grant_timeout", gq.size(), n);
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 200 && rq.size() < n; i++) @(posedge clk);
        #1;
        if (rq.size() < n) chk("rsp_timeout", rq.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int g0, r0, v0;
        rst_n = 1'b0;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single add wrapping past 2^9
        v0 = vcount;
        set_req(0, 1'b1, 300, 300);
        wait_grant(1);
        req_valid[0] = 1'b0;
        wait_rsp(1);
        if (rq.size() >= 1) begin
            chk("t1_id", rq[0].id, 0);
            chk("t1_data", rq[0].data, 88);
            chk("t1_cout", rq[0].cout, 1);
        end
        chk("t1_latency", last_r_cyc - last_g_cyc, 2);
        repeat (2) @(posedge clk);
        #1 chk("t1_valid_cycles", vcount - v0, 1);

        // Subtract with and without borrow
        set_req(2, 1'b0, 5, 9);
        wait_grant(2);
        req_valid[2] = 1'b0;
        wait_rsp(2);
        if (rq.size() >= 2) begin
            chk("t2a_id", rq[1].id, 2);
            chk("t2a_data", rq[1].data, 508);
            chk("t2a_cout", rq[1].cout, 1);
        end
        set_req(2, 1'b0, 9, 5);
        wait_grant(3);
        req_valid[2] = 1'b0;
        wait_rsp(3);
        if (rq.size() >= 3) begin
            chk("t2b_data", rq[2].data, 4);
            chk("t2b_cout", rq[2].cout, 0);
        end

        // Round-robin with all requesters held
        @(posedge clk); #1;
        do_reset();
        g0 = gq.size();
        set_req(0, 1'b1, 1, 2);
        set_req(1, 1'b0, 7, 3);
        set_req(2, 1'b1, 511, 1);
        set_req(3, 1'b0, 0, 0);
        wait_grant(g0 + 8);
        req_valid = '0;
        for (int k = 0; k < 8; k++)
            if (gq.size() > g0 + k) chk("t3_order", gq[g0 + k], k % NREQ);
        for (int i = 0; i < 20 && busy; i++) @(posedge clk);
        #1;

        // Backpressure: result held 5 cycles while rsp_ready is low
        rsp_ready = 1'b0;
        g0 = gq.size();
        set_req(0, 1'b1, 100, 27);
        set_req(1, 1'b0, 3, 3);
        wait_grant(g0 + 1);
        req_valid[0] = 1'b0;
        if (gq.size() > g0) chk("t4_first", gq[g0], 0);
        for (int i = 0; i < 20 && !rsp_valid; i++) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_data", rsp_data, 127);
            chk("t4_hold_ready", req_ready, 0);
        end
        chk("t4_no_grant", gq.size(), g0 + 1);
        rsp_ready = 1'b1;
        wait_grant(g0 + 2);
        req_valid[1] = 1'b0;
        if (gq.size() > g0 + 1) chk("t4_second", gq[g0 + 1], 1);
        r0 = rq.size();
        wait_rsp(r0 + 1);
        if (rq.size() > r0) begin
            chk("t4_sub_data", rq[r0].data, 0);
            chk("t4_sub_cout", rq[r0].cout, 0);
        end
        repeat (2) @(posedge clk); #1;

        // Reset during EXEC discards the result; rr pointer restarts at 0
        g0 = gq.size();
        set_req(0, 1'b1, 1, 2);
        wait_grant(g0 + 1);
        v0 = vcount;
        r0 = rq.size();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_valid", vcount - v0, 0);
        set_req(1, 1'b1, 10, 20);
        set_req(3, 1'b0, 0, 1);
        rst_n = 1'b1;
        wait_grant(g0 + 2);
        req_valid[1] = 1'b0;
        if (gq.size() > g0 + 1) chk("t5_first", gq[g0 + 1], 1);
        wait_grant(g0 + 3);
        req_valid[3] = 1'b0;
        wait_rsp(r0 + 2);
        if (rq.size() >= r0 + 2) begin
            chk("t5_id1", rq[r0].id, 1);
            chk("t5_data1", rq[r0].data, 30);
            chk("t5_id3", rq[r0 + 1].id, 3);
            chk("t5_data3", rq[r0 + 1].data, 511);
            chk("t5_cout3", rq[r0 + 1].cout, 1);
        end
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
